// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional build macro used by instr_fetch_unit: FETCH_PERF_CNT_EN.
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } ifu_state_t;

  // RV32I instruction field positions
  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned OPCODE_W   = 7;
  localparam int unsigned RD_LSB     = 7;
  localparam int unsigned RD_W       = 5;
  localparam int unsigned FUNC3_LSB  = 12;
  localparam int unsigned FUNC3_W    = 3;
  localparam int unsigned RS1_LSB    = 15;
  localparam int unsigned RS1_W      = 5;
  localparam int unsigned RS2_LSB    = 20;
  localparam int unsigned RS2_W      = 5;
  localparam int unsigned FUNC7_LSB  = 25;
  localparam int unsigned FUNC7_W    = 7;
  localparam int unsigned IMM_LSB    = 12;
  localparam int unsigned IMM_W      = 20;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/ifu_field_slicer.sv
// Combinational split of a 32-bit RV32I word into its raw fields.
module ifu_field_slicer
  import ifu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [2:0]  func3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  func7,
  output logic [19:0] imm_data
);

  // Pure bit selection; immediate is left raw for the control unit to extend
  always_comb begin
    opcode   = instr[OPCODE_LSB +: OPCODE_W];
    rd       = instr[RD_LSB     +: RD_W];
    func3    = instr[FUNC3_LSB  +: FUNC3_W];
    rs1      = instr[RS1_LSB    +: RS1_W];
    rs2      = instr[RS2_LSB    +: RS2_W];
    func7    = instr[FUNC7_LSB  +: FUNC7_W];
    imm_data = instr[IMM_LSB    +: IMM_W];
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, issues one outstanding imem request,
// registers the returned word and presents its fields over valid/ready.
// Redirects override the next PC and discard any in-flight or held word.
// Build option: define FETCH_PERF_CNT_EN to add perf_fetched/perf_stall counters.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
)
(
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_out,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      func3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      func7,
  output logic [19:0]     imm_data
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall
`endif
);

  ifu_state_t      state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic            drop, drop_nxt;
  logic            out_valid_nxt;
  logic [31:0]     out_word, out_word_nxt;
  logic [XLEN-1:0] pc_out_nxt;
  logic [XLEN-1:0] redirect_tgt;

  assign redirect_tgt = redirect_pc & ~XLEN'(3);
  assign imem_addr    = pc;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state, datapath updates and imem request
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    drop_nxt       = drop;
    out_valid_nxt  = out_valid;
    out_word_nxt   = out_word;
    pc_out_nxt     = pc_out;
    imem_req_valid = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = REQ;
        if (redirect_valid) pc_nxt = redirect_tgt;
      end
      REQ: begin
        imem_req_valid = 1'b1;
        if (redirect_valid) pc_nxt = redirect_tgt;
        if (imem_req_ready) begin
          state_nxt = WAIT;
          // accepted address is already stale if redirected in the same cycle
          drop_nxt  = redirect_valid;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (drop || redirect_valid) begin
            state_nxt = REQ;
            drop_nxt  = 1'b0;
            if (redirect_valid) pc_nxt = redirect_tgt;
          end else begin
            out_valid_nxt = 1'b1;
            out_word_nxt  = imem_rdata;
            pc_out_nxt    = pc;
            state_nxt     = HOLD;
          end
        end else if (redirect_valid) begin
          drop_nxt = 1'b1;
          pc_nxt   = redirect_tgt;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          pc_nxt        = redirect_valid ? redirect_tgt : pc_out + XLEN'(4);
          state_nxt     = REQ;
        end else if (redirect_valid) begin
          out_valid_nxt = 1'b0;
          pc_nxt        = redirect_tgt;
          state_nxt     = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // PC, drop flag and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      drop      <= 1'b0;
      out_valid <= 1'b0;
      out_word  <= '0;
      pc_out    <= RESET_PC;
    end else begin
      pc        <= pc_nxt;
      drop      <= drop_nxt;
      out_valid <= out_valid_nxt;
      out_word  <= out_word_nxt;
      pc_out    <= pc_out_nxt;
    end
  end

  ifu_field_slicer u_slicer (
    .instr    (out_word),
    .opcode   (opcode),
    .rd       (rd),
    .func3    (func3),
    .rs1      (rs1),
    .rs2      (rs2),
    .func7    (func7),
    .imm_data (imm_data)
  );

`ifdef FETCH_PERF_CNT_EN
  // Handshake and backpressure counters, free-running with wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (out_valid && out_ready)  perf_fetched <= perf_fetched + 32'd1;
      if (out_valid && !out_ready) perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: stimulus pushes expected fetch
// addresses and decoded outputs; a negedge monitor pops and compares.
module tb_instr_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic [19:0] imm;
  } exp_t;

  logic        clk, rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] pc_out;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  func3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  func7;
  logic [19:0] imm_data;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall;
`endif

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .pc_out         (pc_out),
    .opcode         (opcode),
    .rd             (rd),
    .func3          (func3),
    .rs1            (rs1),
    .rs2            (rs2),
    .func7          (func7),
    .imm_data       (imm_data)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  int          n_cmp = 0, n_err = 0;
  int          n_acc = 0, n_out = 0, cyc = 0, last_acc = 0, tmo_cnt = 0;
  int          mem_lat = 1;
  logic        chk_reset = 0, chk_hold = 0, chk_perf = 0, lat_chk = 0, end_chk = 0;
  logic [31:0] exp_pf = 0, exp_ps = 0;
  logic [31:0] exp_addr[$];
  exp_t        exp_out[$];

  // Instruction memory contents
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0000_0003;
      32'h0000_0004: return 32'h4000_0033;
      32'h0000_0008: return 32'h00C5_8593;
      32'h0000_000C: return 32'h0020_A023;
      32'h0000_0100: return 32'h0010_0093;
      32'hFFFF_FFFC: return 32'hFFF0_0067;
      default:       return 32'h0000_0013;
    endcase
  endfunction

  // Hand-decoded expected fields for each word above
  function automatic exp_t vec(input logic [31:0] a);
    case (a)
      32'h0000_0000: return '{a, 7'h03, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 20'h00000};
      32'h0000_0004: return '{a, 7'h33, 5'd0,  3'd0, 5'd0,  5'd0,  7'h20, 20'h40000};
      32'h0000_0008: return '{a, 7'h13, 5'd11, 3'd0, 5'd11, 5'd12, 7'h00, 20'h00C58};
      32'h0000_000C: return '{a, 7'h23, 5'd0,  3'd2, 5'd1,  5'd2,  7'h00, 20'h0020A};
      32'h0000_0100: return '{a, 7'h13, 5'd1,  3'd0, 5'd0,  5'd1,  7'h00, 20'h00100};
      32'hFFFF_FFFC: return '{a, 7'h67, 5'd0,  3'd0, 5'd0,  5'd31, 7'h7F, 20'hFFF00};
      default:       return '{a, 7'h13, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 20'h00000};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // imem responder with programmable latency; a reset drops any pending response
  initial begin
    logic        hs, rst_s, pend;
    logic [31:0] hs_addr, pend_addr;
    int          pend_cnt;
    imem_rsp_valid = 0;
    imem_rdata     = '0;
    pend = 0; pend_cnt = 0; pend_addr = '0;
    forever begin
      @(negedge clk);
      hs      = imem_req_valid && imem_req_ready;
      hs_addr = imem_addr;
      rst_s   = rst;
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (rst_s) pend = 0;
      else begin
        if (hs) begin pend = 1; pend_cnt = mem_lat; pend_addr = hs_addr; end
        if (pend) begin
          pend_cnt--;
          if (pend_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rdata     = mem_word(pend_addr);
            pend           = 0;
          end
        end
      end
    end
  end

  // Monitor: every comparison happens here
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] a;
    cyc++;
    if (chk_reset) begin
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_req_valid", 32'(imem_req_valid), 0);
      chk("rst_pc_out", pc_out, 32'h0);
      chk("rst_fields", {opcode, rd, func3, rs1, rs2}, 0);
    end
    if (imem_req_valid && imem_req_ready) begin
      n_acc++;
      last_acc = cyc;
      if (exp_addr.size() == 0) chk("req_unexpected", imem_addr, 32'hDEAD_BEEF);
      else begin
        a = exp_addr.pop_front();
        chk("imem_addr", imem_addr, a);
      end
    end
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_out.size() == 0) chk("out_unexpected", pc_out, 32'hDEAD_BEEF);
      else begin
        e = exp_out.pop_front();
        chk("pc_out", pc_out, e.pc);
        chk("opcode", 32'(opcode), 32'(e.opc));
        chk("rd", 32'(rd), 32'(e.rd));
        chk("func3", 32'(func3), 32'(e.f3));
        chk("rs1", 32'(rs1), 32'(e.rs1));
        chk("rs2", 32'(rs2), 32'(e.rs2));
        chk("func7", 32'(func7), 32'(e.f7));
        chk("imm_data", 32'(imm_data), 32'(e.imm));
        if (lat_chk) chk("accept_to_valid", 32'(cyc - last_acc), 2);
      end
    end
    if (chk_hold) begin
      e = vec(32'h0000_000C);
      chk("hold_out_valid", 32'(out_valid), 1);
      chk("hold_no_req", 32'(imem_req_valid), 0);
      chk("hold_pc_out", pc_out, e.pc);
      chk("hold_fields", {opcode, func3, rs2, imm_data}, 32'({e.opc, e.f3, e.rs2, e.imm}));
    end
`ifdef FETCH_PERF_CNT_EN
    if (chk_perf || end_chk) begin
      chk("perf_fetched", perf_fetched, exp_pf);
      chk("perf_stall", perf_stall, exp_ps);
    end
`endif
    if (end_chk) begin
      chk("addr_left", 32'(exp_addr.size()), 0);
      chk("out_left", 32'(exp_out.size()), 0);
      chk("phase_timeouts", 32'(tmo_cnt), 0);
    end
  end

  // Let the DUT fetch until acc_t requests were accepted and out_t handshakes seen
  task automatic run(input int acc_t, input int out_t);
    bit done = 0;
    imem_req_ready = 1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk); #1;
      if (n_acc >= acc_t) imem_req_ready = 0;
      if (n_acc >= acc_t && n_out >= out_t) done = 1;
    end
    imem_req_ready = 0;
    if (!done) tmo_cnt++;
  endtask

  task automatic expect_fetch(input logic [31:0] a, input bit shown);
    exp_addr.push_back(a);
    if (shown) exp_out.push_back(vec(a));
  endtask

  initial begin
    bit seen;
    rst = 1; imem_req_ready = 0; redirect_valid = 0; redirect_pc = '0;
    out_ready = 1; chk_reset = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0; chk_reset = 0;

    // Sequential fetch 0,4,8 with 1-cycle memory
    lat_chk = 1;
    expect_fetch(32'h0, 1); expect_fetch(32'h4, 1); expect_fetch(32'h8, 1);
    run(3, 3);
    lat_chk = 0;

    // Backpressure: hold word at 0xC for 5 cycles
    out_ready = 0;
    expect_fetch(32'hC, 1);
    imem_req_ready = 1;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk); #1;
      if (n_acc >= 4) imem_req_ready = 0;
      if (out_valid) seen = 1;
    end
    imem_req_ready = 0;
    if (!seen) tmo_cnt++;
    chk_hold = 1;
    repeat (5) begin @(posedge clk); #1; end
    chk_hold = 0;
    exp_pf = 3; exp_ps = 5; chk_perf = 1;
    out_ready = 1;
    @(posedge clk); #1;
    chk_perf = 0;

    // Redirect while waiting on a slow response to 0x10
    mem_lat = 3;
    expect_fetch(32'h10, 0);
    imem_req_ready = 1;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk); #1;
      if (n_acc >= 5) seen = 1;
    end
    if (!seen) tmo_cnt++;
    imem_req_ready = 0;
    redirect_valid = 1; redirect_pc = 32'h100;
    @(posedge clk); #1;
    redirect_valid = 0;
    expect_fetch(32'h100, 1);
    run(6, 5);

    // Redirect in REQ (unaligned target) then wrap past the top of memory
    mem_lat = 1;
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    redirect_valid = 0;
    expect_fetch(32'hFFFF_FFFC, 1); expect_fetch(32'h0, 1);
    run(8, 7);
    exp_pf = 7; exp_ps = 5; chk_perf = 1;
    @(posedge clk); #1;
    chk_perf = 0;

    // Reset in WAIT (with a concurrent redirect that must lose)
    mem_lat = 3;
    expect_fetch(32'h4, 0);
    imem_req_ready = 1;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk); #1;
      if (n_acc >= 9) seen = 1;
    end
    if (!seen) tmo_cnt++;
    imem_req_ready = 0;
    rst = 1; redirect_valid = 1; redirect_pc = 32'h200;
    @(posedge clk); #1;
    redirect_valid = 0;
    @(posedge clk); #1;
    rst = 0;
    mem_lat = 1;
    expect_fetch(32'h0, 1);
    run(10, 8);

    exp_pf = 1; exp_ps = 0;
    end_chk = 1;
    @(posedge clk); #1;
    end_chk = 0;
    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
